// File: rtl/key_cond_pkg.sv
// Shared types, default timing and sizing helpers for the key conditioner.
package key_cond_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } key_state_t;

  // Defaults assume CLOCK_50 (20 ns period).
  localparam int         DEF_DEBOUNCE_CYCLES = 1_000_000; // 20 ms
  localparam int         DEF_REPEAT_DELAY    = 25_000_000; // 0.5 s
  localparam int         DEF_REPEAT_PERIOD   = 5_000_000;  // 0.1 s
  localparam logic [3:0] DEF_REPEAT_MASK     = 4'b0010;

  // Bits needed to hold 0..n-1; never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_one.sv
// One push-button: synchroniser, debouncer and press/repeat/release FSM.
module key_debounce_one
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic held,
  output logic step,
  output logic released
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int HW = cnt_w(max_i(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] RD_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] RP_LAST  = HW'(REPEAT_PERIOD - 1);

  logic          sync1, sync2;
  logic          raw;
  logic [DW-1:0] db_cnt;
  logic          accept, rise, fall;
  key_state_t    state, state_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic          step_nx, rel_nx;

  // Two-flop synchroniser on the raw pin; idles at 1 (not pressed) so a key
  // held through reset is seen as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign raw = ~sync2;

  // A change in raw must persist DEBOUNCE_CYCLES cycles; any agreement restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      held   <= 1'b0;
    end else if (raw == held) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      held   <= raw;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Acceptance is known one cycle early so pulses land on the same edge as held.
  assign accept = (raw != held) && (db_cnt == DB_LAST);
  assign rise   = accept & raw;
  assign fall   = accept & ~raw;

  // FSM registers and registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      step     <= 1'b0;
      released <= 1'b0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      step     <= step_nx;
      released <= rel_nx;
    end
  end

  // Next state: release wins over everything; masked keys saturate in PRESSED.
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    step_nx  = 1'b0;
    rel_nx   = 1'b0;
    if (fall) begin
      state_nx = IDLE;
      hold_nx  = '0;
      rel_nx   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nx = PRESSED;
            step_nx  = 1'b1;
            hold_nx  = '0;
          end
        end
        PRESSED: begin
          if (hold_cnt == RD_LAST) begin
            if (REPEAT_EN) begin
              state_nx = REPEAT;
              step_nx  = 1'b1;
              hold_nx  = '0;
            end
          end else begin
            hold_nx = hold_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (hold_cnt == RP_LAST) begin
            step_nx = 1'b1;
            hold_nx = '0;
          end else begin
            hold_nx = hold_cnt + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          hold_nx  = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Conditions N_KEYS raw active-low buttons into held/step/released signals.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int                N_KEYS          = 4,
  parameter int                DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int                REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int                REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [N_KEYS-1:0] REPEAT_MASK     = N_KEYS'(DEF_REPEAT_MASK)
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] held,
  output logic [N_KEYS-1:0] step,
  output logic [N_KEYS-1:0] released,
  output logic              any_step
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_one #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (REPEAT_MASK[i])
    ) u_key (
      .clk     (CLOCK_50),
      .rst_n   (reset_n),
      .key_n   (key_n[i]),
      .held    (held[i]),
      .step    (step[i]),
      .released(released[i])
    );
  end

  // OR of registered step bits, so it stays glitch-free and in the same cycle.
  assign any_step = |step;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short timing parameters.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic [3:0] held, step, released;
  logic       any_step;

  key_conditioner #(
    .N_KEYS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3), .REPEAT_MASK(4'b0010)
  ) dut (
    .CLOCK_50(clk), .reset_n(rst_n), .key_n(key_n),
    .held(held), .step(step), .released(released), .any_step(any_step)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event logs, sampled mid-cycle; cyc is the index of the posedge just passed.
  int         sq[4][$];
  int         rq[4][$];
  int         aq[$];
  int         hr[4];
  logic [3:0] hprev = 4'h0;
  int         bad_any = 0;
  int         bad_ovl = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (step[k] === 1'b1)     sq[k].push_back(cyc);
      if (released[k] === 1'b1) rq[k].push_back(cyc);
      if (held[k] === 1'b1 && hprev[k] === 1'b0) hr[k] <= cyc;
    end
    if (any_step === 1'b1) aq.push_back(cyc);
    if (any_step !== (|step)) bad_any <= bad_any + 1;
    if ((step & released) != 4'h0) bad_ovl <= bad_ovl + 1;
    hprev <= held;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sget(input int k, input int i);
    if (i >= 0 && i < sq[k].size()) return sq[k][i];
    return -1;
  endfunction

  function automatic int rget(input int k, input int i);
    if (i >= 0 && i < rq[k].size()) return rq[k][i];
    return -1;
  endfunction

  function automatic int aget(input int i);
    if (i >= 0 && i < aq.size()) return aq[i];
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int t0, t1, tl, e0, tr, b0, b1, b2, b3, r0, r1, rr, a0;
  int off[6] = '{0, 10, 13, 16, 19, 22};

  initial begin
    // Reset state
    tick(3);
    chk("rst_held", int'(held), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_released", int'(released), 0);
    chk("rst_any", int'(any_step), 0);
    rst_n = 1'b1;
    tick(8);
    chk("idle_held", int'(held), 0);
    chk("idle_steps", aq.size(), 0);

    // Clean press/release on key 0 (no repeat)
    b0 = sq[0].size(); r0 = rq[0].size();
    t0 = cyc; key_n[0] = 1'b0;
    tick(5);
    chk("press_early_held", int'(held[0]), 0);
    tick(1);
    chk("press_held", int'(held[0]), 1);
    chk("press_step_now", int'(step[0]), 1);
    tick(6);
    t1 = cyc; key_n[0] = 1'b1;
    tick(10);
    chk("press_step_cyc", sget(0, b0), t0 + 6);
    chk("press_step_cnt", sq[0].size() - b0, 1);
    chk("press_held_rise", hr[0], t0 + 6);
    chk("rel_cyc", rget(0, r0), t1 + 6);
    chk("rel_cnt", rq[0].size() - r0, 1);
    chk("rel_held", int'(held[0]), 0);

    // Bounce on key 1, then hold into auto-repeat
    b1 = sq[1].size(); r1 = rq[1].size(); a0 = aq.size();
    for (int i = 0; i < 6; i++) begin
      key_n[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    key_n[1] = 1'b0;
    tl = cyc;
    chk("bounce_no_step", sq[1].size() - b1, 0);
    chk("bounce_no_held", int'(held[1]), 0);
    e0 = tl + 6;
    tick(25);
    key_n[1] = 1'b1; // held falls at e0+25, exactly when a repeat would be due
    tick(12);
    chk("bounce_held_rise", hr[1], e0);
    chk("rpt_step_cnt", sq[1].size() - b1, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rpt_step%0d", i), sget(1, b1 + i), e0 + off[i]);
      chk($sformatf("rpt_any%0d", i), aget(a0 + i), e0 + off[i]);
    end
    chk("rpt_any_cnt", aq.size() - a0, 6);
    chk("rpt_rel_cyc", rget(1, r1), e0 + 25);
    chk("rpt_rel_cnt", rq[1].size() - r1, 1);

    // Masked key 2: one step only
    b2 = sq[2].size();
    t0 = cyc; key_n[2] = 1'b0;
    tick(8);
    chk("mask_held_a", int'(held[2]), 1);
    tick(22);
    chk("mask_held_b", int'(held[2]), 1);
    key_n[2] = 1'b1;
    tick(10);
    chk("mask_step_cnt", sq[2].size() - b2, 1);
    chk("mask_step_cyc", sget(2, b2), t0 + 6);

    // Simultaneous keys 0 and 3
    b0 = sq[0].size(); b3 = sq[3].size(); a0 = aq.size();
    t0 = cyc; key_n = 4'b0110;
    tick(12);
    chk("simul_step0", sget(0, b0), t0 + 6);
    chk("simul_step3", sget(3, b3), t0 + 6);
    chk("simul_any_cnt", aq.size() - a0, 1);
    chk("simul_any_cyc", aget(a0), t0 + 6);
    key_n = 4'hF;
    tick(10);

    // Reset during repeat on key 1, key kept held through reset release
    r1 = rq[1].size();
    t0 = cyc; key_n[1] = 1'b0;
    tick(16); // posedge t0+16 = first repeat step
    chk("pre_rst_step", int'(step[1]), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_held", int'(held), 0);
    chk("rst_async_step", int'(step), 0);
    chk("rst_async_any", int'(any_step), 0);
    tick(3);
    b1 = sq[1].size(); rr = rq[1].size();
    chk("rst_no_rel", rr - r1, 0);
    rst_n = 1'b1;
    tr = cyc;
    tick(26);
    key_n[1] = 1'b1;
    tick(12);
    chk("rst_step0", sget(1, b1), tr + 6);
    chk("rst_step1", sget(1, b1 + 1), tr + 16);
    chk("rst_step2", sget(1, b1 + 2), tr + 19);
    chk("rst_rel_cnt", rq[1].size() - rr, 1);
    chk("rst_rel_cyc", rget(1, rr), tr + 32);

    chk("any_mirror", bad_any, 0);
    chk("no_overlap", bad_ovl, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
